// File: rtl/sseg_update_sched.sv
// sseg_update_sched: shares the 8-digit serial seven-segment display between two
// requesters, issues one Start per frame and waits for the device's SEG_PEN edge.
// It also re-sends the current content periodically and generates the blink phase.
module sseg_update_sched #(
    parameter int REFRESH_CYC = 1_000_000,
    parameter int FLASH_DIV   = 25_000_000,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] hexs0,
    input  logic [7:0]  les0,
    input  logic [7:0]  pt0,
    input  logic [31:0] hexs1,
    input  logic [7:0]  les1,
    input  logic [7:0]  pt1,
    input  logic        seg_pen,
    output logic [1:0]  ack,
    output logic [31:0] Hexs,
    output logic [7:0]  LES,
    output logic [7:0]  point,
    output logic        flash,
    output logic        Start,
    output logic        busy,
    output logic        err
);
    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RW-1:0] REFRESH_LOAD = RW'(REFRESH_CYC - 1);
    localparam logic [RW-1:0] R_ONE        = RW'(1);
    localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_DIV - 1);
    localparam logic [FW-1:0] F_ONE        = FW'(1);
    // START occupies the first cycle of the window, so WAIT lasts TIMEOUT-1 cycles
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 2);
    localparam logic [TW-1:0] T_ONE        = TW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t        state;
    state_t        state_nx;
    logic          rr_last;
    logic          winner;
    logic          grant_sel;
    logic          refresh_due;
    logic [RW-1:0] refresh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [FW-1:0] flash_cnt;
    logic          seg_pen_d;
    logic          pen_rise;
    logic          tmo_hit;

    // Round-robin choice: on a tie the requester not served last wins
    assign grant_sel = (req == 2'b11) ? ~rr_last : req[1];
    assign pen_rise  = seg_pen & ~seg_pen_d;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: requests take priority over a pending refresh
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req != 2'b00)    state_nx = LOAD;
                else if (refresh_due) state_nx = START;
            end
            LOAD:  state_nx = START;
            START: state_nx = WAIT;
            WAIT: begin
                if (pen_rise || tmo_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: pulses come straight from the current state
    always_comb begin
        ack = 2'b00;
        if (state == LOAD) ack[winner] = 1'b1;
        Start = (state == START);
        busy  = (state != IDLE);
    end

    // Grant capture, content load and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            winner  <= 1'b0;
            rr_last <= 1'b1;
            Hexs    <= '0;
            LES     <= '0;
            point   <= '0;
        end else begin
            if (state == IDLE) winner <= grant_sel;
            if (state == LOAD) begin
                Hexs    <= winner ? hexs1 : hexs0;
                LES     <= winner ? les1  : les0;
                point   <= winner ? pt1   : pt0;
                rr_last <= winner;
            end
        end
    end

    // Refresh timer: runs only while idle, re-armed when a transfer ends
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= REFRESH_LOAD;
            refresh_due <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (refresh_cnt != '0) begin
                        refresh_cnt <= refresh_cnt - R_ONE;
                        if (refresh_cnt == R_ONE) refresh_due <= 1'b1;
                    end
                end
                START: refresh_due <= 1'b0;
                WAIT: begin
                    if (pen_rise || tmo_hit) refresh_cnt <= REFRESH_LOAD;
                end
                default: ;
            endcase
        end
    end

    // SEG_PEN edge detector, completion timeout and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_pen_d <= 1'b0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            seg_pen_d <= seg_pen;
            if (state == START)
                tmo_cnt <= '0;
            else if (state == WAIT && !tmo_hit)
                tmo_cnt <= tmo_cnt + T_ONE;
            if (state == WAIT && !pen_rise && tmo_hit)
                err <= 1'b1;
        end
    end

    // Free-running blink divider, independent of the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cnt <= '0;
            flash     <= 1'b0;
        end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            flash     <= ~flash;
        end else begin
            flash_cnt <= flash_cnt + F_ONE;
        end
    end

endmodule

// File: tb/tb_sseg_update_sched.sv
// Directed + randomized bench for sseg_update_sched with a transaction-level model.
module tb_sseg_update_sched;
    localparam int RCYC = 100;
    localparam int FDIV = 3;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] hexs0, hexs1;
    logic [7:0]  les0, pt0, les1, pt1;
    logic        seg_pen;
    logic [1:0]  ack;
    logic [31:0] Hexs;
    logic [7:0]  LES, point;
    logic        flash, Start, busy, err;

    int checks = 0;
    int errors = 0;
    int k = 0;

    // Reference model state: what the display should currently hold
    logic [31:0] m_hexs;
    logic [7:0]  m_les, m_pt;
    int          m_rr;
    logic        m_err;

    sseg_update_sched #(.REFRESH_CYC(RCYC), .FLASH_DIV(FDIV), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .hexs0(hexs0), .les0(les0), .pt0(pt0),
        .hexs1(hexs1), .les1(les1), .pt1(pt1),
        .seg_pen(seg_pen), .ack(ack), .Hexs(Hexs), .LES(LES), .point(point),
        .flash(flash), .Start(Start), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; the blink phase is (k / FDIV) mod 2
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flash();
        chk("flash", {31'd0, flash}, 32'((k / FDIV) % 2));
    endtask

    task automatic rand_data(input int i);
        if (i == 0) begin
            hexs0 = $urandom; les0 = 8'($urandom); pt0 = 8'($urandom);
        end else begin
            hexs1 = $urandom; les1 = 8'($urandom); pt1 = 8'($urandom);
        end
    endtask

    task automatic model_reset();
        m_hexs = '0; m_les = '0; m_pt = '0; m_rr = 1; m_err = 1'b0;
    endtask

    // One frame. Enters on a negedge; waits for ack (request) or Start (refresh).
    // pen_delay > 0: pulse seg_pen that many cycles after Start; 0: never (timeout);
    // < 0: return at the Start cycle leaving the frame in progress.
    task automatic xfer(input bit is_req, input int pen_delay, input int exp_wait, input bit drop);
        int n;
        int w;
        n = 0;
        while (ack == 2'b00 && Start == 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 2000) else begin
            errors++;
            $error("FAIL wait_bound: waited %0d cycles, required under 2000", n);
            return;
        end
        if (exp_wait >= 0) chk("latency", n, exp_wait);
        w = 0;
        if (is_req) begin
            if (req == 2'b11) w = (m_rr == 1) ? 0 : 1;
            else              w = req[1] ? 1 : 0;
            chk("ack", {30'd0, ack}, 32'(1 << w));
            m_hexs = w ? hexs1 : hexs0;
            m_les  = w ? les1  : les0;
            m_pt   = w ? pt1   : pt0;
            m_rr   = w;
            @(negedge clk);
        end
        chk("start", {31'd0, Start}, 1);
        chk("ack_at_start", {30'd0, ack}, 0);
        chk("hexs", Hexs, m_hexs);
        chk("les", {24'd0, LES}, {24'd0, m_les});
        chk("point", {24'd0, point}, {24'd0, m_pt});
        chk("busy_start", {31'd0, busy}, 1);
        chk_flash();
        if (is_req) begin
            rand_data(w);
            if (drop) req[w] = 1'b0;
        end
        if (pen_delay < 0) return;
        if (pen_delay == 0) begin
            repeat (TMO - 1) @(negedge clk);
            chk("busy_before_tmo", {31'd0, busy}, 1);
            @(negedge clk);
            chk("busy_after_tmo", {31'd0, busy}, 0);
            m_err = 1'b1;
            chk("err_tmo", {31'd0, err}, {31'd0, m_err});
        end else begin
            repeat (pen_delay) @(negedge clk);
            chk("busy_wait", {31'd0, busy}, 1);
            chk("start_once", {31'd0, Start}, 0);
            seg_pen = 1'b1;
            @(negedge clk);
            seg_pen = 1'b0;
            chk("busy_done", {31'd0, busy}, 0);
            chk("err_hold", {31'd0, err}, {31'd0, m_err});
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; seg_pen = 1'b0;
        rand_data(0); rand_data(1);
        model_reset();

        // T1: reset values, then the blank refresh frame
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_start", {31'd0, Start}, 0);
        chk("rst_ack", {30'd0, ack}, 0);
        chk("rst_hexs", Hexs, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk_flash();
        rst = 1'b0;
        xfer(0, 12, 1, 0);

        // T3: both requesters held for four transfers, rq0 first
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 3 + i, 1, 0);
            chk("t3_order", 32'(m_rr), 32'(i % 2));
        end
        req = 2'b00;

        // T2: single request; a high seg_pen level must not end the frame
        hexs0 = 32'h1234_ABCD;
        req = 2'b01;
        seg_pen = 1'b1;
        xfer(1, -1, 1, 1);
        chk("t2_hexs", Hexs, 32'h1234_ABCD);
        repeat (4) @(negedge clk);
        chk("t2_level_ignored", {31'd0, busy}, 1);
        seg_pen = 1'b0;
        @(negedge clk);
        seg_pen = 1'b1;
        @(negedge clk);
        seg_pen = 1'b0;
        chk("t2_edge_done", {31'd0, busy}, 0);

        // T4: no completion -> timeout, sticky err, next request still served
        req = 2'b10;
        xfer(1, 0, 1, 1);
        req = 2'b01;
        xfer(1, 3, 1, 1);

        // Randomized requests and completion delays
        for (int i = 0; i < 12; i++) begin
            req = 2'($urandom_range(1, 3));
            xfer(1, $urandom_range(1, TMO - 2), 1, 1'($urandom_range(0, 1)));
        end
        req = 2'b00;

        // T5: idle refreshes re-send the same content without ack
        for (int i = 0; i < 3; i++) xfer(0, $urandom_range(1, 8), RCYC, 0);

        // T6: reset mid-WAIT with rq1 pending
        req = 2'b01;
        xfer(1, -1, 1, 1);
        repeat (2) @(negedge clk);
        req = 2'b10;
        rand_data(1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_start", {31'd0, Start}, 0);
        chk("t6_ack", {30'd0, ack}, 0);
        chk("t6_hexs", Hexs, 0);
        chk("t6_les", {24'd0, LES}, 0);
        chk("t6_point", {24'd0, point}, 0);
        chk("t6_err", {31'd0, err}, 0);
        chk_flash();
        rst = 1'b0;
        req = 2'b00;
        xfer(0, 5, 1, 0);
        req = 2'b10;
        xfer(1, 5, 1, 1);
        chk("t6_req1_hexs", Hexs, m_hexs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
